// File: rtl/uivtc_pkg.sv
// Shared definitions for the PiP mixer slice.
//   mix_state_t  : mixer frame-tracking states (IDLE after reset, SYNC while vs
//                  is high, RUN once a full vs pulse has been seen)
//   PIX_W_DEF    : default RGB pixel width
//   sat_inc16    : saturating 16-bit increment for the statistics counters
package uivtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } mix_state_t;

  localparam int          PIX_W_DEF  = 24;
  localparam logic [15:0] UF_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == UF_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uivtc_pip_mixer_if.sv
// Window pixel FIFO read port.
//   O_fifo_rd    : read strobe from the mixer, data valid one cycle later
//   I_fifo_data  : FIFO read data
//   I_fifo_empty : FIFO has no data
// master = mixer side (issues reads), slave = FIFO side.
interface uivtc_pip_mixer_if
  import uivtc_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
);
  logic             O_fifo_rd;
  logic [PIX_W-1:0] I_fifo_data;
  logic             I_fifo_empty;

  modport master (output O_fifo_rd, input I_fifo_data, input I_fifo_empty);
  modport slave  (input O_fifo_rd, output I_fifo_data, output I_fifo_empty);
endinterface

// File: rtl/uivtc_edge_det.sv
// Single-bit rise/fall detector.
//   clk, rst : clock, asynchronous active-high reset
//   din      : level to watch
//   rise     : din is 1 now and was 0 last cycle
//   fall     : din is 0 now and was 1 last cycle
// RST_VAL is the assumed previous level after reset; setting it to 1 means a
// level that is already high when reset releases is not reported as a rise.
module uivtc_edge_det
  import uivtc_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) din_d <= RST_VAL;
    else     din_d <= din;
  end

  assign rise = din & ~din_d;
  assign fall = ~din & din_d;

endmodule

// File: rtl/uivtc_pip_mixer.sv
// Picture-in-picture mixer: overlays window pixels read from a FIFO onto a
// background colour, with an optional 1-pixel border, 2-cycle video latency.
//   I_mix_clk, I_mix_rst          : pixel clock, async active-high reset
//   I_vtc_vs/hs/de, I_win_de      : timing and window enable from the generator
//   I_bg_rgb, I_border_rgb        : background / border colours
//   I_border_en                   : enable the window border
//   fifo (master)                 : window FIFO read port
//   O_frame_start                 : one-cycle pulse after each vs rising edge
//   O_vs/hs/de, O_rgb             : mixed video, 2 cycles after the inputs
//   O_uf_cnt, O_uf_sticky         : FIFO underflow statistics
//   I_clr_err                     : synchronous clear of the statistics
module uivtc_pip_mixer
  import uivtc_pkg::*;
#(
  parameter int WIN_V = 480,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             I_mix_clk,
  input  logic             I_mix_rst,
  input  logic             I_vtc_vs,
  input  logic             I_vtc_hs,
  input  logic             I_vtc_de,
  input  logic             I_win_de,
  input  logic [PIX_W-1:0] I_bg_rgb,
  input  logic [PIX_W-1:0] I_border_rgb,
  input  logic             I_border_en,
  uivtc_pip_mixer_if.master fifo,
  output logic             O_frame_start,
  output logic             O_vs,
  output logic             O_hs,
  output logic             O_de,
  output logic [PIX_W-1:0] O_rgb,
  output logic [15:0]      O_uf_cnt,
  output logic             O_uf_sticky,
  input  logic             I_clr_err
);

  localparam int                LINE_W    = (WIN_V > 1) ? $clog2(WIN_V) : 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(WIN_V - 1);

  function automatic logic [PIX_W-1:0] mix_pix(
    input logic             de,
    input logic             rd,
    input logic             border,
    input logic [PIX_W-1:0] fifo_px,
    input logic [PIX_W-1:0] bg,
    input logic [PIX_W-1:0] brd
  );
    if (!de)    return '0;
    if (!rd)    return bg;
    if (border) return brd;
    return fifo_px;
  endfunction

  mix_state_t        state, state_nxt;
  logic              vs_rise, vs_fall, win_rise, win_fall;
  logic              run, rd_s, uf_s;
  logic [LINE_W-1:0] line_cnt;

  logic              vs_p1, hs_p1, de_p1, win_p1, first_p1, rd_p1, fs_p1;
  logic              vs_p2, hs_p2, de_p2;
  logic [PIX_W-1:0]  rgb_p2;
  logic              border_p1;
  logic [15:0]       uf_cnt;
  logic              uf_sticky;

  uivtc_edge_det #(.RST_VAL(1'b1)) u_vs_edge (
    .clk(I_mix_clk), .rst(I_mix_rst), .din(I_vtc_vs), .rise(vs_rise), .fall(vs_fall)
  );

  uivtc_edge_det #(.RST_VAL(1'b0)) u_win_edge (
    .clk(I_mix_clk), .rst(I_mix_rst), .din(I_win_de), .rise(win_rise), .fall(win_fall)
  );

  always_ff @(posedge I_mix_clk or posedge I_mix_rst) begin
    if (I_mix_rst) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // A vs rise always restarts the frame, even mid-window; reads resume only
  // after the matching vs fall.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (vs_rise) state_nxt = ST_SYNC;
      ST_SYNC: if (vs_fall) state_nxt = ST_RUN;
      ST_RUN:  if (vs_rise) state_nxt = ST_SYNC;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage 0: read request / underflow decision on live inputs ----
  assign run            = (state == ST_RUN);
  assign rd_s           = I_win_de & I_vtc_de & ~fifo.I_fifo_empty & run;
  assign uf_s           = I_win_de & I_vtc_de & fifo.I_fifo_empty & run;
  assign fifo.O_fifo_rd = rd_s;

  // Window line index; held at zero outside RUN so a restarted frame cannot
  // carry a stale count from an interrupted line.
  always_ff @(posedge I_mix_clk or posedge I_mix_rst) begin
    if (I_mix_rst)                    line_cnt <= '0;
    else if (O_frame_start || !run)   line_cnt <= '0;
    else if (win_fall && line_cnt != LAST_LINE)
                                      line_cnt <= line_cnt + LINE_W'(1);
  end

  always_ff @(posedge I_mix_clk or posedge I_mix_rst) begin
    if (I_mix_rst) begin
      uf_cnt    <= '0;
      uf_sticky <= 1'b0;
    end else if (I_clr_err) begin
      uf_cnt    <= '0;
      uf_sticky <= 1'b0;
    end else if (uf_s) begin
      uf_cnt    <= sat_inc16(uf_cnt);
      uf_sticky <= 1'b1;
    end
  end

  always_ff @(posedge I_mix_clk or posedge I_mix_rst) begin
    if (I_mix_rst) begin
      vs_p1 <= 1'b0; hs_p1 <= 1'b0; de_p1 <= 1'b0; win_p1 <= 1'b0;
      first_p1 <= 1'b0; rd_p1 <= 1'b0; fs_p1 <= 1'b0;
    end else begin
      vs_p1    <= I_vtc_vs;
      hs_p1    <= I_vtc_hs;
      de_p1    <= I_vtc_de;
      win_p1   <= I_win_de;
      first_p1 <= win_rise;
      rd_p1    <= rd_s;
      fs_p1    <= vs_rise;
    end
  end

  // ---- stage 1: FIFO data arrives; border decision and pixel select ----
  // The last window pixel is recognised when the window enable has already
  // dropped at stage 0 while stage 1 still holds a window pixel.
  assign border_p1 = I_border_en &
                     (first_p1 | (win_p1 & ~I_win_de) |
                      (line_cnt == '0) | (line_cnt == LAST_LINE));

  always_ff @(posedge I_mix_clk or posedge I_mix_rst) begin
    if (I_mix_rst) begin
      vs_p2 <= 1'b0; hs_p2 <= 1'b0; de_p2 <= 1'b0; rgb_p2 <= '0;
    end else begin
      vs_p2  <= vs_p1;
      hs_p2  <= hs_p1;
      de_p2  <= de_p1;
      rgb_p2 <= mix_pix(de_p1, rd_p1, border_p1, fifo.I_fifo_data, I_bg_rgb, I_border_rgb);
    end
  end

  // ---- stage 2: registered outputs ----
  assign O_vs          = vs_p2;
  assign O_hs          = hs_p2;
  assign O_de          = de_p2;
  assign O_rgb         = rgb_p2;
  assign O_frame_start = fs_p1;
  assign O_uf_cnt      = uf_cnt;
  assign O_uf_sticky   = uf_sticky;

endmodule

// File: tb/tb_uivtc_pip_mixer.sv
`timescale 1ns/1ps
module tb_uivtc_pip_mixer;

  localparam int WIN_V = 4;
  localparam int PIX_W = 24;
  localparam int H_TOT = 22, H_ACT = 16, V_TOT = 13, V_ACT = 10;
  localparam int WY0 = 3, WX0 = 4, WX1 = 11;
  localparam logic [23:0] BG  = 24'h204060;
  localparam logic [23:0] BRD = 24'hFF0000;
  localparam logic [23:0] CPX = 24'h123456;

  logic I_mix_clk = 1'b0;
  logic I_mix_rst = 1'b1;
  logic I_vtc_vs = 1'b0, I_vtc_hs = 1'b0, I_vtc_de = 1'b0, I_win_de = 1'b0;
  logic I_border_en = 1'b0, I_clr_err = 1'b0;
  logic [PIX_W-1:0] I_bg_rgb = BG, I_border_rgb = BRD;
  logic O_frame_start, O_vs, O_hs, O_de, O_uf_sticky;
  logic [PIX_W-1:0] O_rgb;
  logic [15:0] O_uf_cnt;

  uivtc_pip_mixer_if #(.PIX_W(PIX_W)) fif();

  uivtc_pip_mixer #(.WIN_V(WIN_V), .PIX_W(PIX_W)) dut (
    .I_mix_clk(I_mix_clk), .I_mix_rst(I_mix_rst),
    .I_vtc_vs(I_vtc_vs), .I_vtc_hs(I_vtc_hs), .I_vtc_de(I_vtc_de), .I_win_de(I_win_de),
    .I_bg_rgb(I_bg_rgb), .I_border_rgb(I_border_rgb), .I_border_en(I_border_en),
    .fifo(fif),
    .O_frame_start(O_frame_start), .O_vs(O_vs), .O_hs(O_hs), .O_de(O_de), .O_rgb(O_rgb),
    .O_uf_cnt(O_uf_cnt), .O_uf_sticky(O_uf_sticky), .I_clr_err(I_clr_err)
  );

  always #5 I_mix_clk = ~I_mix_clk;

  int checks = 0, failures = 0;
  int rd_total = 0, fs_total = 0, brd_seen = 0, cpx_seen = 0;
  int vs_rises = 0;
  logic last_vs = 1'b0;
  logic const_mode = 1'b0;
  int tag_col = -1, tag_wl = -1;
  int pop_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO behaviour: each read pops the next word, visible the following cycle.
  always @(posedge I_mix_clk or posedge I_mix_rst) begin
    if (I_mix_rst) begin
      fif.I_fifo_data <= '0;
    end else if (fif.O_fifo_rd) begin
      fif.I_fifo_data <= const_mode ? CPX : (24'hA00000 + 24'(pop_cnt));
      pop_cnt <= pop_cnt + 1;
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  typedef struct {
    logic vs, hs, de, win, empty, rd, rise, ben;
    logic [23:0] data;
    int col, wl;
  } ent_t;

  ent_t h1, h2;
  logic m_run, m_armed, m_prev_vs, m_sticky;
  logic [15:0] m_cnt;

  always @(negedge I_mix_clk) begin
    ent_t e;
    logic [23:0] er;
    logic uf;
    e = '{default: 0};
    e.vs = I_vtc_vs; e.hs = I_vtc_hs; e.de = I_vtc_de; e.win = I_win_de;
    e.empty = fif.I_fifo_empty; e.ben = I_border_en; e.data = fif.I_fifo_data;
    e.col = tag_col; e.wl = tag_wl;
    if (I_mix_rst) begin
      chk("reset_outputs",
          {O_vs, O_hs, O_de, O_frame_start, O_uf_sticky, fif.O_fifo_rd, O_rgb, O_uf_cnt}, '0);
      m_run = 1'b0; m_armed = 1'b0; m_prev_vs = 1'b1; m_sticky = 1'b0; m_cnt = '0;
      h1 = '{default: 0}; h2 = '{default: 0};
    end else begin
      e.rise = e.vs & ~m_prev_vs;
      // reads only while in a frame that began with a complete vs pulse
      e.rd = e.win & e.de & ~e.empty & m_run;
      chk("fifo_rd", fif.O_fifo_rd, e.rd);
      if (!h2.de) er = '0;
      else if (!h2.rd) er = BG;
      else if (h2.ben && (h2.col == WX0 || h2.col == WX1 || h2.wl == 0 || h2.wl == WIN_V-1)) er = BRD;
      else er = h1.data;
      chk("video", {O_vs, O_hs, O_de, O_frame_start, O_rgb}, {h2.vs, h2.hs, h2.de, h1.rise, er});
      chk("underflow_stats", {O_uf_sticky, O_uf_cnt}, {m_sticky, m_cnt});
      uf = e.win & e.de & e.empty & m_run;
      if (I_clr_err) begin m_cnt = '0; m_sticky = 1'b0; end
      else if (uf) begin m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1; m_sticky = 1'b1; end
      if (e.rise) begin m_run = 1'b0; m_armed = 1'b1; end
      else if (!e.vs && m_prev_vs && m_armed) m_run = 1'b1;
      m_prev_vs = e.vs;
      h2 = h1; h1 = e;
      if (fif.O_fifo_rd) rd_total++;
      if (O_frame_start) fs_total++;
      if (O_de && O_rgb == BRD) brd_seen++;
      if (O_de && O_rgb == CPX) cpx_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic v, input logic h, input logic d, input logic w,
                     input logic em, input int c, input int l);
    @(posedge I_mix_clk); #1;
    if (v && !last_vs) vs_rises++;
    last_vs = v;
    I_vtc_vs = v; I_vtc_hs = h; I_vtc_de = d; I_win_de = w;
    fif.I_fifo_empty = em; tag_col = c; tag_wl = l;
  endtask

  // Active lines first, vs pulse in the vertical blanking at the end.
  task automatic frame(input bit ufm, input int stop_l, input int stop_c);
    for (int l = 0; l < V_TOT; l++) begin
      for (int c = 0; c < H_TOT; c++) begin
        logic d, w, em;
        int wl;
        if (l == stop_l && c == stop_c) return;
        d  = (l < V_ACT) && (c < H_ACT);
        wl = l - WY0;
        w  = d && (wl >= 0) && (wl < WIN_V) && (c >= WX0) && (c <= WX1);
        em = ufm && w && (wl == 1 || (wl == 2 && c < WX0 + 2));
        cyc(l == V_ACT + 1, (c >= H_ACT + 1) && (c < H_ACT + 3), d, w, em, c, wl);
      end
    end
  endtask

  initial begin
    int r0, b0, c0;
    fif.I_fifo_empty = 1'b0;
    repeat (3) @(posedge I_mix_clk);
    #1;
    chk("reset_uf_cnt", O_uf_cnt, 16'd0);
    chk("reset_video", {O_vs, O_hs, O_de, O_frame_start, O_rgb}, '0);
    I_mix_rst = 1'b0;

    // first frame after reset shows only background, second is fully read
    r0 = rd_total; frame(0, -1, -1);
    chk("frame1_reads", rd_total - r0, 0);
    r0 = rd_total; frame(0, -1, -1);
    chk("frame2_reads", rd_total - r0, 32);

    // bordered window with constant FIFO data
    I_border_en = 1'b1; const_mode = 1'b1;
    r0 = rd_total; b0 = brd_seen; c0 = cpx_seen;
    frame(0, -1, -1);
    chk("border_reads", rd_total - r0, 32);
    chk("border_pixels", brd_seen - b0, 20);
    chk("interior_pixels", cpx_seen - c0, 12);
    I_border_en = 1'b0; const_mode = 1'b0;

    // ten window pixels with an empty FIFO
    r0 = rd_total;
    frame(1, -1, -1);
    chk("uf_frame_reads", rd_total - r0, 22);
    chk("uf_cnt_10", O_uf_cnt, 16'd10);
    chk("uf_sticky_set", O_uf_sticky, 1'b1);

    // clear wins over a simultaneous underflow
    cyc(0, 0, 1, 1, 1, -1, -1); I_clr_err = 1'b1;
    cyc(0, 0, 0, 0, 0, -1, -1); I_clr_err = 1'b0;
    chk("clr_priority", {O_uf_sticky, O_uf_cnt}, 17'd0);

    // drive the counter to its ceiling and 5 beyond
    repeat (65540) cyc(0, 0, 1, 1, 1, -1, -1);
    cyc(0, 0, 0, 0, 0, -1, -1);
    chk("uf_saturate", O_uf_cnt, 16'hFFFF);
    chk("uf_sticky_sat", O_uf_sticky, 1'b1);
    cyc(0, 0, 0, 0, 0, -1, -1); I_clr_err = 1'b1;
    cyc(0, 0, 0, 0, 0, -1, -1); I_clr_err = 1'b0;
    chk("uf_clear", O_uf_cnt, 16'd0);

    // vs rising in the middle of a window line restarts the frame
    frame(0, 4, 7);
    cyc(1, 0, 1, 1, 0, 7, 1);
    repeat (21) cyc(1, 0, 0, 0, 0, -1, -1);
    repeat (22) cyc(0, 0, 0, 0, 0, -1, -1);
    r0 = rd_total; frame(0, -1, -1);
    chk("restart_reads", rd_total - r0, 32);

    // reset in the middle of a window line
    frame(0, 5, 6);
    @(posedge I_mix_clk); #1;
    I_mix_rst = 1'b1;
    #1;
    chk("midline_rst_de", {O_de, O_vs, O_hs}, 3'b000);
    chk("midline_rst_rgb", O_rgb, 24'd0);
    chk("midline_rst_rd", fif.O_fifo_rd, 1'b0);
    repeat (2) @(posedge I_mix_clk);
    #1;
    I_mix_rst = 1'b0;
    I_vtc_vs = 1'b0; I_vtc_hs = 1'b0; I_vtc_de = 1'b0; I_win_de = 1'b0;
    fif.I_fifo_empty = 1'b0; tag_col = -1; tag_wl = -1; last_vs = 1'b0;
    r0 = rd_total; frame(0, -1, -1);
    chk("post_rst_frame1_reads", rd_total - r0, 0);
    r0 = rd_total; frame(0, -1, -1);
    chk("post_rst_frame2_reads", rd_total - r0, 32);

    repeat (5) cyc(0, 0, 0, 0, 0, -1, -1);
    chk("frame_start_per_vs", fs_total, vs_rises);
    chk("vs_rises_total", vs_rises, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uivtc_pip_mixer.md
UIVTC_PIP_MIXER -- requirements
Module: uivtc_pip_mixer

Interface
REQ-001 SHALL have parameter WIN_V, default 480, window height in lines.
REQ-002 SHALL have parameter PIX_W, default 24, RGB pixel width.
REQ-003 SHALL have port I_mix_clk  input  1  single pixel clock.
REQ-004 SHALL have port I_mix_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports I_vtc_vs / I_vtc_hs / I_vtc_de  input  1 each  timing from the upstream timing generator.
REQ-006 SHALL have port I_win_de  input  1  window (PiP) data-enable from the same generator.
REQ-007 SHALL have ports I_bg_rgb / I_border_rgb  input  PIX_W each  background and border colours, quasi-static.
REQ-008 SHALL have port I_border_en  input  1  enables the 1-pixel window border.
REQ-009 SHALL have port O_fifo_rd  output  1  read strobe to the window pixel FIFO; data valid one cycle later.
REQ-010 SHALL have ports I_fifo_data  input  PIX_W and I_fifo_empty  input  1.
REQ-011 SHALL have port O_frame_start  output  1  one-cycle pulse per frame, used to rewind the frame buffer reader.
REQ-012 SHALL have ports O_vs / O_hs / O_de  output  1 each and O_rgb  output  PIX_W  mixed video.
REQ-013 SHALL have ports O_uf_cnt  output  16 and O_uf_sticky  output  1  underflow statistics; I_clr_err  input  1  synchronous clear.

Function
REQ-014 SHALL implement states IDLE (after reset), SYNC (vs high), RUN; IDLE->SYNC and RUN->SYNC on I_vtc_vs rising edge; SYNC->RUN on I_vtc_vs falling edge.
REQ-015 SHALL pulse O_frame_start for exactly one cycle, the cycle after each I_vtc_vs rising edge.
REQ-016 SHALL drive O_fifo_rd combinationally = I_win_de & I_vtc_de & ~I_fifo_empty & (state==RUN).
REQ-017 SHALL delay O_vs/O_hs/O_de by exactly 2 cycles relative to the inputs; O_rgb aligns with O_de.
REQ-018 SHALL output I_fifo_data in pixels where a read was issued 2 cycles earlier and the pixel is not border.
REQ-019 SHALL output I_bg_rgb where O_de=1 and no window pixel applies, including all pixels in IDLE and the first partial frame.
REQ-020 SHALL output all-zero O_rgb when O_de=0.
REQ-021 SHALL count window lines per frame (0..WIN_V-1) at each I_win_de falling edge, clearing on O_frame_start.
REQ-022 SHALL, when I_border_en=1, replace with I_border_rgb the first and last window pixel of each window line and every pixel of window lines 0 and WIN_V-1; border pixels still consume FIFO data.
REQ-023 SHALL detect last window pixel in a line by I_win_de=0 at stage 0 while stage 1 holds a window pixel.
REQ-024 SHALL treat a RUN-state window pixel with I_fifo_empty=1 as underflow: no read, pixel shows I_bg_rgb, O_uf_cnt +1, O_uf_sticky set.
REQ-025 SHALL saturate O_uf_cnt at 16'hFFFF.
REQ-026 SHALL give I_clr_err priority over a simultaneous underflow: both counter and sticky read zero next cycle.
REQ-027 SHALL treat a vs rising edge during a window line as frame restart: line count cleared, state SYNC, no reads until RUN.

Reset
REQ-028 SHALL, on I_mix_rst=1, immediately force state IDLE, all pipeline registers, O_vs/O_hs/O_de/O_frame_start/O_uf_sticky to 0, O_rgb to 0, O_uf_cnt to 0, O_fifo_rd to 0.
REQ-029 SHALL resume only after I_mix_rst deasserts, first reads occurring after the next full vs pulse.

Structure
REQ-030 SHALL place state encoding (IDLE/SYNC/RUN) and PIX_W default in shared package uivtc_pkg.
REQ-031 SHALL use one sub-module, uivtc_edge_det, for vs and win_de rise/fall detection.

Verification
REQ-032 Reset then 1024x600 timing, FIFO always non-empty, WIN_V=480, 640 window -> first frame all bg; frame 2 exactly 307200 reads, O_rgb=FIFO data, O_de 2 cycles after I_vtc_de.
REQ-033 I_border_en=1, FIFO data 24'h123456, border 24'hFF0000 -> window line 0 and 479 all FF0000, columns first/last FF0000, interior 123456, reads still 307200.
REQ-034 Force I_fifo_empty=1 for 10 window pixels -> 10 bg pixels, no O_fifo_rd, O_uf_cnt=10, sticky=1.
REQ-035 Underflow and I_clr_err same cycle -> O_uf_cnt=0, sticky=0 next cycle; counter preset near 16'hFFFF plus 5 underflows -> stays FFFF.
REQ-036 Assert I_mix_rst mid-window line -> outputs 0 same cycle; after release, no reads until after next vs pulse; exactly one O_frame_start per vs rising edge.
